// File: rtl/crc5_engine_if.sv
// Byte-stream and status bundle between a transmitter and crc5_engine.
// The receive-check signals exist only when CRC_RX_CHECK_EN is defined.
interface crc5_engine_if;
    logic       i_tx_crc_en;
    logic [7:0] i_tx_parallel_data;
    logic       i_ddrccc_crc_init;
    logic [4:0] o_tx_crc_value;
    logic       o_crc_value_valid;
    logic       o_crc_busy;
    logic       o_crc_overflow;
`ifdef CRC_RX_CHECK_EN
    logic       i_rx_crc_check;
    logic [4:0] i_rx_crc_value;
    logic       o_crc_error;
`endif

    modport slave (
`ifdef CRC_RX_CHECK_EN
        input  i_rx_crc_check,
        input  i_rx_crc_value,
        output o_crc_error,
`endif
        input  i_tx_crc_en,
        input  i_tx_parallel_data,
        input  i_ddrccc_crc_init,
        output o_tx_crc_value,
        output o_crc_value_valid,
        output o_crc_busy,
        output o_crc_overflow
    );

    modport master (
`ifdef CRC_RX_CHECK_EN
        output i_rx_crc_check,
        output i_rx_crc_value,
        input  o_crc_error,
`endif
        output i_tx_crc_en,
        output i_tx_parallel_data,
        output i_ddrccc_crc_init,
        input  o_tx_crc_value,
        input  o_crc_value_valid,
        input  o_crc_busy,
        input  o_crc_overflow
    );
endinterface

// File: rtl/crc5_engine.sv
// Bit-serial CRC-5 (x^5+x^2+1, MSB first) fed through a 2-entry byte FIFO.
// Optional receive-side compare is enabled by defining CRC_RX_CHECK_EN.
module crc5_engine #(
    parameter logic [4:0] CRC_INIT = 5'b11111
) (
    input  logic          i_sys_clk,
    input  logic          i_sys_rst,
    crc5_engine_if.slave  bus
);
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CRC_W      = 5;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FILL_W     = 2;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_d [FIFO_DEPTH];
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                seen_q, seen_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic                pop_c;
    logic                full_c;
`ifdef CRC_RX_CHECK_EN
    logic                err_q, err_d;
`endif

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic d);
        logic fb;
        fb = c[4] ^ d;
        return {c[3], c[2], c[1] ^ fb, c[0], fb};
    endfunction

    // Next-state: init wins over everything, then FSM/FIFO, then the new byte is pushed.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        fifo_d    = fifo_q;
        fill_d    = fill_q;
        seen_d    = seen_q;
        ovf_d     = ovf_q;
        pop_c     = 1'b0;
        full_c    = (fill_q == FILL_W'(FIFO_DEPTH));
`ifdef CRC_RX_CHECK_EN
        err_d     = err_q;
`endif

        if (bus.i_ddrccc_crc_init) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            crc_d     = CRC_INIT;
            fill_d    = '0;
            seen_d    = 1'b0;
            ovf_d     = 1'b0;
`ifdef CRC_RX_CHECK_EN
            err_d     = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fill_q != '0) begin
                        pop_c     = 1'b1;
                        shift_d   = fifo_q[0];
                        bit_cnt_d = CNT_W'(7);
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    crc_d     = crc_step(crc_q, shift_q[DATA_W-1]);
                    shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    if (bit_cnt_q == '0) begin
                        seen_d = 1'b1;
                        // Back-to-back reload keeps the shifter busy with no idle cycle.
                        if (fill_q != '0) begin
                            pop_c     = 1'b1;
                            shift_d   = fifo_q[0];
                            bit_cnt_d = CNT_W'(7);
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (pop_c) begin
                fifo_d[0] = fifo_q[1];
                fill_d    = fill_q - FILL_W'(1);
            end
            if (bus.i_tx_crc_en && full_c) begin
                ovf_d = 1'b1;
            end
`ifdef CRC_RX_CHECK_EN
            if (bus.i_rx_crc_check && valid_q && (bus.i_rx_crc_value != crc_q)) begin
                err_d = 1'b1;
            end
`endif
        end

        if (bus.i_tx_crc_en && (bus.i_ddrccc_crc_init || !full_c)) begin
            fifo_d[fill_d[0]] = bus.i_tx_parallel_data;
            fill_d            = fill_d + FILL_W'(1);
        end

        valid_d = (state_d == IDLE) && (fill_d == '0) && seen_d;
        busy_d  = (state_d == SHIFT) || (fill_d != '0);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            crc_q     <= CRC_INIT;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            fill_q    <= '0;
            seen_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef CRC_RX_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            fifo_q    <= fifo_d;
            fill_q    <= fill_d;
            seen_q    <= seen_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
`ifdef CRC_RX_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign bus.o_tx_crc_value    = crc_q;
    assign bus.o_crc_value_valid = valid_q;
    assign bus.o_crc_busy        = busy_q;
    assign bus.o_crc_overflow    = ovf_q;
`ifdef CRC_RX_CHECK_EN
    assign bus.o_crc_error       = err_q;
`endif
endmodule

// File: tb/tb_crc5_engine.sv
// Scoreboard bench for crc5_engine: a transaction-level model predicts each
// frame's CRC, overflow flag and the cycle o_crc_value_valid rises.
module tb_crc5_engine;
    localparam logic [4:0] INIT = 5'b11111;

    typedef struct {
        logic [4:0] crc;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    int   busy_cycles;
    exp_t sbq[$];

    // Reference model state (frame level)
    logic [4:0] m_crc;
    logic       m_ovf;
    logic       m_any;
    int         m_last_pop;
    int         q_pops[$];

    crc5_engine_if bus();

    crc5_engine #(.CRC_INIT(INIT)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Polynomial remainder of (crc*x^8 + data*x^5) mod (x^5+x^2+1)
    function automatic logic [4:0] ref_crc_byte(input logic [4:0] c, input logic [7:0] d);
        logic [12:0] v;
        v = (13'(c) << 8) ^ (13'(d) << 5);
        for (int i = 12; i >= 5; i--) begin
            if (v[i]) v = v ^ (13'h25 << (i - 5));
        end
        return v[4:0];
    endfunction

    function automatic void model_clear();
        m_crc      = INIT;
        m_ovf      = 1'b0;
        m_any      = 1'b0;
        m_last_pop = -100;
        q_pops.delete();
    endfunction

    // A byte waits in the FIFO until it is popped, one pop per 8-cycle slot.
    function automatic void model_strobe(input int t, input bit en, input logic [7:0] d, input bit init);
        int p;
        if (init) model_clear();
        if (en) begin
            while (q_pops.size() > 0 && q_pops[0] < t) void'(q_pops.pop_front());
            if (q_pops.size() >= 2) begin
                m_ovf = 1'b1;
            end else begin
                p = (t + 1 > m_last_pop + 8) ? t + 1 : m_last_pop + 8;
                q_pops.push_back(p);
                m_last_pop = p;
                m_crc      = ref_crc_byte(m_crc, d);
                m_any      = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input bit en, input logic [7:0] d, input bit init);
        bus.i_tx_crc_en        = en;
        bus.i_tx_parallel_data = d;
        bus.i_ddrccc_crc_init  = init;
        model_strobe(cyc, en, d, init);
        tick();
        bus.i_tx_crc_en       = 1'b0;
        bus.i_ddrccc_crc_init = 1'b0;
    endtask

    task automatic finish_burst();
        int drain;
        if (m_any) begin
            drain = m_last_pop + 9;
            sbq.push_back('{crc: m_crc, ovf: m_ovf, cyc: drain});
            while (cyc <= drain) tick();
            chk("valid_seen", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_crc"},   32'(bus.o_tx_crc_value),    32'(INIT));
        chk({tag, "_valid"}, 32'(bus.o_crc_value_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.o_crc_busy),        32'd0);
        chk({tag, "_ovf"},   32'(bus.o_crc_overflow),    32'd0);
    endtask

`ifdef CRC_RX_CHECK_EN
    task automatic rx_check(input logic [4:0] v);
        bus.i_rx_crc_check = 1'b1;
        bus.i_rx_crc_value = v;
        tick();
        bus.i_rx_crc_check = 1'b0;
    endtask
`endif

    // Monitor: each rising edge of valid retires one scoreboard entry
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.o_crc_busy === 1'b1) busy_cycles++;
                if (bus.o_crc_value_valid === 1'b1 && !prev_valid) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_crc",   32'(bus.o_tx_crc_value), 32'(e.crc));
                        chk("sb_ovf",   32'(bus.o_crc_overflow), 32'(e.ovf));
                        chk("sb_cycle", 32'(cyc),                32'(e.cyc));
                    end
                end
                prev_valid = (bus.o_crc_value_valid === 1'b1);
            end
        end
    end

    initial begin
        int n, gap, mode;
        errors      = 0;
        checks      = 0;
        busy_cycles = 0;
        rst_n       = 1'b0;
        bus.i_tx_crc_en        = 1'b0;
        bus.i_tx_parallel_data = '0;
        bus.i_ddrccc_crc_init  = 1'b0;
`ifdef CRC_RX_CHECK_EN
        bus.i_rx_crc_check = 1'b0;
        bus.i_rx_crc_value = '0;
`endif
        model_clear();
        idle(3);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // First strobe right after reset release, seed from reset
        drive(1'b1, 8'hAA, 1'b0);
        finish_burst();

        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'hAA, 1'b0);
        finish_burst();
        chk("aa_crc",   32'(bus.o_tx_crc_value),    32'h17);
        chk("aa_valid", 32'(bus.o_crc_value_valid), 32'd1);

        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h00, 1'b0);
        finish_burst();
        chk("zero_crc", 32'(bus.o_tx_crc_value), 32'h0F);
        chk("zero_ovf", 32'(bus.o_crc_overflow), 32'd0);

        // Two bytes back to back
        busy_cycles = 0;
        drive(1'b1, 8'hAA, 1'b1);
        drive(1'b1, 8'hC9, 1'b0);
        finish_burst();
        chk("b2b_busy_cycles", 32'(busy_cycles), 32'd17);

        // Fill the FIFO while shifting: last byte dropped
        drive(1'b1, 8'h3C, 1'b1);
        idle(3);
        drive(1'b1, 8'h81, 1'b0);
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        chk("ovf_set", 32'(bus.o_crc_overflow), 32'd1);
        finish_burst();

        // Valid drops after a strobe continuing the frame
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'hAA, 1'b0);
        finish_burst();
        drive(1'b1, 8'h55, 1'b0);
        chk("valid_drop", 32'(bus.o_crc_value_valid), 32'd0);
        finish_burst();

        // Init with a byte mid-shift aborts the byte in progress
        drive(1'b1, 8'hE7, 1'b1);
        idle(4);
        drive(1'b1, 8'h12, 1'b1);
        finish_burst();

        // Asynchronous reset mid-shift
        drive(1'b1, 8'h99, 1'b1);
        idle(3);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_clear();
        idle(2);
        rst_n = 1'b1;
        tick();
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'hAA, 1'b0);
        finish_burst();
        chk("post_rst_crc", 32'(bus.o_tx_crc_value), 32'h17);

`ifdef CRC_RX_CHECK_EN
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'hAA, 1'b0);
        rx_check(5'b00000);
        chk("rx_ignored", 32'(bus.o_crc_error), 32'd0);
        finish_burst();
        rx_check(5'b10111);
        chk("rx_match", 32'(bus.o_crc_error), 32'd0);
        rx_check(5'b10110);
        chk("rx_mismatch", 32'(bus.o_crc_error), 32'd1);
        idle(3);
        chk("rx_sticky", 32'(bus.o_crc_error), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        chk("rx_init_clear", 32'(bus.o_crc_error), 32'd0);
`endif

        // Random bursts: gaps of at most 6 idle cycles keep each burst one frame
        for (int b = 0; b < 40; b++) begin
            mode = $urandom_range(0, 2);
            n    = $urandom_range(1, 5);
            if (mode == 0) begin
                drive(1'b0, 8'h00, 1'b1);
                idle($urandom_range(0, 2));
            end
            for (int k = 0; k < n; k++) begin
                drive(1'b1, 8'($urandom_range(0, 255)), (mode == 1) && (k == 0));
                gap = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 0;
                if (k != n - 1) idle(gap);
            end
            finish_burst();
            idle($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
